if_id_frontend: RTL and testbench

- Fetch front end: owns the PC register and the IF/ID pipeline register.
- Consumes the load-use stall controls (pc_write, if_id_write) from the decode-stage hazard detector.
- Consumes the branch-taken redirect (flush) from EX.
- Presents the fetched instruction and its register-number fields (if_id_rn1, if_id_rn2) back to the hazard detector and the decode stage.

---
 rtl/if_id_frontend.sv | 86 ++++++++
 tb/tb_if_id_frontend.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_frontend.sv
// Fetch front end: PC register plus IF/ID pipeline register with stall and flush control.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_frontend #(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_write,
   input  logic               if_id_write,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               if_id_valid,
   output logic [3:0]         if_id_rn1,
   output logic [3:0]         if_id_rn2,
   output logic [15:0]        stall_cycles,
   output logic [15:0]        flush_count
);

   logic [ADDR_W-1:0] pc;

   assign imem_addr = pc;
   assign if_id_rn1 = if_id_instr[7:4];
   assign if_id_rn2 = if_id_instr[3:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
   // the flush branch relies on this to capture the old pc into if_id_pc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (flush) begin
         pc          <= branch_target;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= pc;
         if_id_valid <= 1'b0;
      end else begin
         // PC and IF/ID enables are independent; stall combinations may mix freely
         if (pc_write) begin
            pc <= pc + ADDR_W'(1);
         end
         if (if_id_write) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
         end
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   // Saturating counters; cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!flush && !pc_write && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (flush && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cnt;
   assign flush_count  = flush_cnt;
`else
   assign stall_cycles = 16'h0000;
   assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_frontend.sv
// Bench for if_id_frontend: two instances (RESET_PC 0 and 16'hFFFF) share control inputs,
// a per-cycle model comparison runs on the falling edge, and directed literal checks pin the model.
module tb_if_id_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        if_id_write;
   logic        flush;
   logic [15:0] branch_target;

   logic [15:0] addr_a, rdata_a, instr_a, ipc_a, sc_a, fc_a;
   logic [15:0] addr_b, rdata_b, instr_b, ipc_b, sc_b, fc_b;
   logic        valid_a, valid_b;
   logic [3:0]  rn1_a, rn2_a, rn1_b, rn2_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Instruction memory image: two fixed words, then a pattern derived from the address
   function automatic logic [15:0] imem(input logic [15:0] a);
      case (a)
         16'h0000: imem = 16'h1234;
         16'h0001: imem = 16'h5678;
         default:  imem = {~a[7:0], a[7:0]};
      endcase
   endfunction

   assign rdata_a = imem(addr_a);
   assign rdata_b = imem(addr_b);

   if_id_frontend dut_a (
      .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
      .flush(flush), .branch_target(branch_target), .imem_addr(addr_a),
      .imem_rdata(rdata_a), .if_id_instr(instr_a), .if_id_pc(ipc_a),
      .if_id_valid(valid_a), .if_id_rn1(rn1_a), .if_id_rn2(rn2_a),
      .stall_cycles(sc_a), .flush_count(fc_a)
   );

   if_id_frontend #(.RESET_PC(16'hFFFF)) dut_b (
      .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
      .flush(flush), .branch_target(branch_target), .imem_addr(addr_b),
      .imem_rdata(rdata_b), .if_id_instr(instr_b), .if_id_pc(ipc_b),
      .if_id_valid(valid_b), .if_id_rn1(rn1_b), .if_id_rn2(rn2_b),
      .stall_cycles(sc_b), .flush_count(fc_b)
   );

   // Behavioural model: per instance the PC, the fetched word it latched and where it came from
   logic [15:0] m_pc[2];
   logic [15:0] m_instr[2];
   logic [15:0] m_ipc[2];
   logic        m_valid[2];
   int          m_stalls;
   int          m_flushes;
   logic [15:0] reset_pc[2];

   initial begin
      reset_pc[0] = 16'h0000;
      reset_pc[1] = 16'hFFFF;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_pc[k]    = reset_pc[k];
            m_instr[k] = 16'h0000;
            m_ipc[k]   = 16'h0000;
            m_valid[k] = 1'b0;
         end
         m_stalls  = 0;
         m_flushes = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (flush) begin
               m_ipc[k]   = m_pc[k];
               m_instr[k] = 16'h0000;
               m_valid[k] = 1'b0;
               m_pc[k]    = branch_target;
            end else begin
               if (if_id_write) begin
                  m_instr[k] = imem(m_pc[k]);
                  m_ipc[k]   = m_pc[k];
                  m_valid[k] = 1'b1;
               end
               if (pc_write) m_pc[k] = 16'((int'(m_pc[k]) + 1) % 65536);
            end
         end
         if (flush) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : m_flushes;
         else if (!pc_write) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : m_stalls;
      end
   end

   function automatic logic [15:0] exp_cnt(input int v);
`ifdef IF_ID_PERF_CNT_EN
      exp_cnt = 16'(v);
`else
      exp_cnt = (v >= 0) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge outside reset: both instances against the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("a.imem_addr", addr_a, m_pc[0]);
         check("a.instr", instr_a, m_instr[0]);
         check("a.if_id_pc", ipc_a, m_ipc[0]);
         check("a.valid", 16'(valid_a), 16'(m_valid[0]));
         check("a.rn1", 16'(rn1_a), 16'(m_instr[0][7:4]));
         check("a.rn2", 16'(rn2_a), 16'(m_instr[0][3:0]));
         check("a.stall_cycles", sc_a, exp_cnt(m_stalls));
         check("a.flush_count", fc_a, exp_cnt(m_flushes));
         check("b.imem_addr", addr_b, m_pc[1]);
         check("b.instr", instr_b, m_instr[1]);
         check("b.if_id_pc", ipc_b, m_ipc[1]);
         check("b.valid", 16'(valid_b), 16'(m_valid[1]));
         check("b.rn1", 16'(rn1_b), 16'(m_instr[1][7:4]));
         check("b.rn2", 16'(rn2_b), 16'(m_instr[1][3:0]));
      end
   end

   // One clock: drive controls, take the edge, settle just after it
   task automatic cyc(input logic pw, input logic iw, input logic fl, input logic [15:0] bt);
      pc_write      = pw;
      if_id_write   = iw;
      flush         = fl;
      branch_target = bt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; flush = 1'b0; branch_target = 16'h0000;
      #1 rst = 1'b1;
      #1;
      check("reset imem_addr", addr_a, 16'h0000);
      check("reset instr", instr_a, 16'h0000);
      check("reset valid", 16'(valid_a), 16'h0000);
      check("reset b imem_addr", addr_b, 16'hFFFF);
      check("reset counters", sc_a | fc_a, 16'h0000);
      @(posedge clk); #1 rst = 1'b0;

      // Free run
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("run1 instr", instr_a, 16'h1234);
      check("run1 if_id_pc", ipc_a, 16'h0000);
      check("run1 valid", 16'(valid_a), 16'h0001);
      check("run1 rn1", 16'(rn1_a), 16'h0003);
      check("run1 rn2", 16'(rn2_a), 16'h0004);
      check("wrap b if_id_pc", ipc_b, 16'hFFFF);
      check("wrap b imem_addr", addr_b, 16'h0000);
      check("wrap b valid", 16'(valid_b), 16'h0001);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("run2 instr", instr_a, 16'h5678);
      check("run2 if_id_pc", ipc_a, 16'h0001);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("pre-stall pc", addr_a, 16'h0005);

      // One-cycle load-use stall at pc=5
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      check("stall pc", addr_a, 16'h0005);
      check("stall if_id_pc", ipc_a, 16'h0004);
      check("stall instr", instr_a, 16'hFB04);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("release pc", addr_a, 16'h0006);
      check("release if_id_pc", ipc_a, 16'h0005);
      check("release instr", instr_a, 16'hFA05);

      // Flush wins over pc_write=0
      cyc(1'b0, 1'b1, 1'b1, 16'h0040);
      check("flush pc", addr_a, 16'h0040);
      check("flush instr", instr_a, 16'h0000);
      check("flush valid", 16'(valid_a), 16'h0000);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("post-flush instr", instr_a, 16'hBF40);
      check("post-flush if_id_pc", ipc_a, 16'h0040);
      check("post-flush valid", 16'(valid_a), 16'h0001);

      // Mixed stall controls
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      check("reload pc", addr_a, 16'h0041);
      check("reload if_id_pc", ipc_a, 16'h0041);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("hold-ifid pc", addr_a, 16'h0042);
      check("hold-ifid if_id_pc", ipc_a, 16'h0041);

      // Back-to-back flushes, then invalid until a real IF/ID load
      cyc(1'b1, 1'b1, 1'b1, 16'h0100);
      cyc(1'b1, 1'b1, 1'b1, 16'h0200);
      check("b2b pc", addr_a, 16'h0200);
      check("b2b if_id_pc", ipc_a, 16'h0100);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("b2b still invalid", 16'(valid_a), 16'h0000);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("b2b valid", 16'(valid_a), 16'h0001);
      check("b2b first pc", ipc_a, 16'h0201);

      // Asynchronous reset during a stall, released before the next edge
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      #2 rst = 1'b1;
      #1;
      check("async rst pc", addr_a, 16'h0000);
      check("async rst valid", 16'(valid_a), 16'h0000);
      check("async rst if_id_pc", ipc_a, 16'h0000);
      check("async rst counters", sc_a | fc_a, 16'h0000);
      #2 rst = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("after rst instr", instr_a, 16'h1234);
      check("after rst if_id_pc", ipc_a, 16'h0000);

      // Counter scenario: 3 stalls, 2 flushes
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 16'h0010);
`ifdef IF_ID_PERF_CNT_EN
      check("stall_cycles", sc_a, 16'd3);
      check("flush_count", fc_a, 16'd2);
`else
      check("stall_cycles off", sc_a, 16'd0);
      check("flush_count off", fc_a, 16'd0);
`endif
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
